// File: rtl/key_entry_sequencer.sv
// key_entry_sequencer
//   Keypad front end for the six-digit lock controller. Collects decoded key
//   presses into a six-digit buffer (with backspace, clear and an idle
//   timeout) and, on ENTER with a full buffer, replays it on the pair-load
//   bus: pair 1/2/3 then a judge phase, each held HOLD cycles.
//
// Ports
//   clk        in   1  system clock, rising edge
//   clr_n      in   1  asynchronous active-low reset
//   key_valid  in   1  key strobe, key_code valid in this cycle
//   key_code   in   4  0-9 digit, A backspace, B enter, C clear, D-F ignored
//   in_a/in_b  out  4  current digit pair
//   a1/a0      out  1  select code (00/01/10 pairs, 11 judge)
//   sel_en     out  1  a send phase is being driven
//   busy       out  1  SEND1 through JUDGE
//   digit_cnt  out  3  buffered digit count 0..6
//   done       out  1  pulse after judge phase
//   reject     out  1  pulse on ENTER with fewer than six digits
//   timeout    out  1  pulse when the idle timer discards the buffer

module key_entry_sequencer #(
    parameter int HOLD    = 2,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] in_a,
    output logic [3:0] in_b,
    output logic       a1,
    output logic       a0,
    output logic       sel_en,
    output logic       busy,
    output logic [2:0] digit_cnt,
    output logic       done,
    output logic       reject,
    output logic       timeout
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_SEND1,
        S_SEND2,
        S_SEND3,
        S_JUDGE
    } state_t;

    state_t          r_state, w_nxt;
    logic [3:0]      r_ph, w_ph;
    logic [TW-1:0]   r_tmr, w_tmr;
    logic [2:0]      r_cnt, w_cnt;
    logic [5:0][3:0] r_d;
    logic            w_wr;

    logic [3:0]      r_in_a, r_in_b, w_in_a, w_in_b;
    logic            r_a1, r_a0, w_a1, w_a0;
    logic            r_sel_en, r_busy, w_sel_en, w_busy;
    logic            r_done, r_reject, r_timeout;
    logic            w_done, w_reject, w_timeout;
    logic            w_key_acc;

    // Keys only count while collecting; 0xD-0xF are not accepted and so
    // neither act nor restart the idle timer.
    assign w_key_acc = key_valid && (r_state == S_COLLECT) && (key_code <= 4'hC);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_COLLECT;
            r_ph    <= '0;
        end else begin
            r_state <= w_nxt;
            r_ph    <= w_ph;
        end
    end

    always_comb begin
        w_nxt     = r_state;
        w_ph      = r_ph;
        w_cnt     = r_cnt;
        w_tmr     = r_tmr;
        w_wr      = 1'b0;
        w_done    = 1'b0;
        w_reject  = 1'b0;
        w_timeout = 1'b0;

        unique case (r_state)
            S_COLLECT: begin
                w_ph = '0;
                if (w_key_acc) begin
                    w_tmr = '0;
                    if (key_code <= 4'h9) begin
                        if (r_cnt < 3'd6) begin
                            w_wr  = 1'b1;
                            w_cnt = r_cnt + 3'd1;
                        end
                    end else if (key_code == 4'hA) begin
                        if (r_cnt != 3'd0) w_cnt = r_cnt - 3'd1;
                    end else if (key_code == 4'hB) begin
                        if (r_cnt == 3'd6) begin
                            w_nxt = S_SEND1;
                        end else begin
                            w_reject = 1'b1;
                            w_cnt    = 3'd0;
                        end
                    end else begin
                        w_cnt = 3'd0;
                    end
                end else if (r_cnt != 3'd0) begin
                    // A key in the expiry cycle takes the branch above, so
                    // it always beats the timeout.
                    if (r_tmr == TW'(TIMEOUT - 1)) begin
                        w_cnt     = 3'd0;
                        w_timeout = 1'b1;
                        w_tmr     = '0;
                    end else begin
                        w_tmr = r_tmr + TW'(1);
                    end
                end else begin
                    w_tmr = '0;
                end
            end
            S_SEND1, S_SEND2, S_SEND3, S_JUDGE: begin
                w_tmr = '0;
                if (r_ph == 4'(HOLD - 1)) begin
                    w_ph = '0;
                    case (r_state)
                        S_SEND1: w_nxt = S_SEND2;
                        S_SEND2: w_nxt = S_SEND3;
                        S_SEND3: w_nxt = S_JUDGE;
                        default: begin
                            w_nxt  = S_COLLECT;
                            w_cnt  = 3'd0;
                            w_done = 1'b1;
                        end
                    endcase
                end else begin
                    w_ph = r_ph + 4'd1;
                end
            end
            default: begin
                w_nxt = S_COLLECT;
                w_ph  = '0;
                w_cnt = 3'd0;
                w_tmr = '0;
            end
        endcase
    end

    // Bus values are decoded from the next state so they register on the
    // same edge as the state change.
    always_comb begin
        w_in_a   = 4'h0;
        w_in_b   = 4'h0;
        w_a1     = 1'b0;
        w_a0     = 1'b0;
        w_sel_en = 1'b1;
        w_busy   = 1'b1;
        unique case (w_nxt)
            S_SEND1: begin
                w_in_a = r_d[0];
                w_in_b = r_d[1];
            end
            S_SEND2: begin
                w_in_a = r_d[2];
                w_in_b = r_d[3];
                w_a0   = 1'b1;
            end
            S_SEND3: begin
                w_in_a = r_d[4];
                w_in_b = r_d[5];
                w_a1   = 1'b1;
            end
            S_JUDGE: begin
                w_in_a = r_d[4];
                w_in_b = r_d[5];
                w_a1   = 1'b1;
                w_a0   = 1'b1;
            end
            default: begin
                w_sel_en = 1'b0;
                w_busy   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt     <= '0;
            r_tmr     <= '0;
            r_d       <= '0;
            r_in_a    <= '0;
            r_in_b    <= '0;
            r_a1      <= 1'b0;
            r_a0      <= 1'b0;
            r_sel_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_reject  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt;
            r_tmr     <= w_tmr;
            if (w_wr) r_d[r_cnt] <= key_code;
            r_in_a    <= w_in_a;
            r_in_b    <= w_in_b;
            r_a1      <= w_a1;
            r_a0      <= w_a0;
            r_sel_en  <= w_sel_en;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_reject  <= w_reject;
            r_timeout <= w_timeout;
        end
    end

    assign in_a      = r_in_a;
    assign in_b      = r_in_b;
    assign a1        = r_a1;
    assign a0        = r_a0;
    assign sel_en    = r_sel_en;
    assign busy      = r_busy;
    assign digit_cnt = r_cnt;
    assign done      = r_done;
    assign reject    = r_reject;
    assign timeout   = r_timeout;

endmodule
